// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow logic: FSM encoding, match
// length and serve-direction constants.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_SERVE_WAIT = 3'd2,
    ST_RALLY      = 3'd3,
    ST_POINT      = 3'd4,
    ST_SETTLE     = 3'd5,
    ST_CHECK      = 3'd6,
    ST_OVER       = 3'd7
  } state_t;

  localparam int   WIN_SCORE = 7;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // The ball only moves during a rally; every other state keeps it centred.
  function automatic logic hold_in_state(input state_t s);
    return (s != ST_RALLY);
  endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Signal bundle between match_ctrl and the start button, ball logic and
// score counter.
interface match_ctrl_if;
  import pong_pkg::*;

  // No valid/ready pairs here: start, playing and winner are levels, while
  // out_*, point*, score_clear and serve_go are single-cycle pulses that are
  // consumed in the cycle they are high, with no back-pressure.
  logic   start;
  logic   out_left;
  logic   out_right;
  logic   playing;
  logic   winner;
  logic   point1;
  logic   point2;
  logic   score_clear;
  logic   ball_hold;
  logic   serve_go;
  logic   serve_dir;
  logic   game_over;
  logic   winner_out;
  state_t dbg_state;

  modport master (
    input  start, out_left, out_right, playing, winner,
    output point1, point2, score_clear, ball_hold, serve_go, serve_dir,
           game_over, winner_out, dbg_state
  );

  modport slave (
    output start, out_left, out_right, playing, winner,
    input  point1, point2, score_clear, ball_hold, serve_go, serve_dir,
           game_over, winner_out, dbg_state
  );

endinterface

// File: rtl/match_ctrl_serve_timer.sv
// Serve-delay down-counter: load sets it to SERVE_DELAY-1, en counts it down
// to zero where it sticks until the next load.
module serve_timer #(
  parameter int SERVE_DELAY = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int            TW       = $clog2(SERVE_DELAY + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(SERVE_DELAY - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/match_ctrl.sv
// Pong game-flow sequencer: starts matches, holds and serves the ball, turns
// ball-out events into score pulses and detects the end of a match.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_DELAY = 50_000_000
) (
  input logic          clk,
  input logic          reset,
  match_ctrl_if.master bus
);

  state_t state_q;
  state_t state_d;
  logic   start_q;
  logic   start_d;
  logic   point1_q;
  logic   point1_d;
  logic   point2_q;
  logic   point2_d;
  logic   score_clear_q;
  logic   score_clear_d;
  logic   serve_go_q;
  logic   serve_go_d;
  logic   serve_dir_q;
  logic   serve_dir_d;
  logic   game_over_q;
  logic   game_over_d;
  logic   winner_out_q;
  logic   winner_out_d;

  logic   start_rise;
  logic   timer_load;
  logic   timer_en;
  logic   timer_zero;
  logic   hit_right;
  logic   hit_left;
  logic   hit_both;

  // start_q powers up high so a button held through reset is not an edge.
  assign start_d    = bus.start;
  assign start_rise = bus.start & ~start_q;

  assign hit_right = bus.out_right & ~bus.out_left;
  assign hit_left  = bus.out_left & ~bus.out_right;
  assign hit_both  = bus.out_left & bus.out_right;

  assign timer_en = (state_q == ST_SERVE_WAIT);

  serve_timer #(
    .SERVE_DELAY(SERVE_DELAY)
  ) u_serve_timer (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .en   (timer_en),
    .zero (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b1;
      point1_q      <= 1'b0;
      point2_q      <= 1'b0;
      score_clear_q <= 1'b0;
      serve_go_q    <= 1'b0;
      serve_dir_q   <= DIR_LEFT;
      game_over_q   <= 1'b0;
      winner_out_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      point1_q      <= point1_d;
      point2_q      <= point2_d;
      score_clear_q <= score_clear_d;
      serve_go_q    <= serve_go_d;
      serve_dir_q   <= serve_dir_d;
      game_over_q   <= game_over_d;
      winner_out_q  <= winner_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        timer_load = 1'b1;
        state_d    = ST_SERVE_WAIT;
      end
      ST_SERVE_WAIT: begin
        if (timer_zero) state_d = ST_RALLY;
      end
      ST_RALLY: begin
        // A simultaneous exit on both sides is a let: re-serve, no point.
        if (hit_both) begin
          timer_load = 1'b1;
          state_d    = ST_SERVE_WAIT;
        end else if (hit_left || hit_right) begin
          state_d = ST_POINT;
        end
      end
      ST_POINT: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!bus.playing) begin
          state_d = ST_OVER;
        end else begin
          timer_load = 1'b1;
          state_d    = ST_SERVE_WAIT;
        end
      end
      ST_OVER: begin
        if (start_rise) state_d = ST_CLEAR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pulses are registered so each lands in the cycle of the state it belongs to.
  always_comb begin
    point1_d      = (state_q == ST_RALLY) && hit_right;
    point2_d      = (state_q == ST_RALLY) && hit_left;
    score_clear_d = (state_d == ST_CLEAR);
    serve_go_d    = (state_q == ST_SERVE_WAIT) && timer_zero;
    serve_dir_d   = serve_dir_q;
    game_over_d   = game_over_q;
    winner_out_d  = winner_out_q;
    if (point1_d) begin
      serve_dir_d = DIR_RIGHT;
    end else if (point2_d) begin
      serve_dir_d = DIR_LEFT;
    end
    if ((state_q == ST_CHECK) && !bus.playing) begin
      game_over_d  = 1'b1;
      winner_out_d = bus.winner;
    end else if ((state_q == ST_OVER) && start_rise) begin
      game_over_d = 1'b0;
    end
  end

  assign bus.point1      = point1_q;
  assign bus.point2      = point2_q;
  assign bus.score_clear = score_clear_q;
  assign bus.ball_hold   = hold_in_state(state_q);
  assign bus.serve_go    = serve_go_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner_out  = winner_out_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with SERVE_DELAY=4, driving it against a
// small behavioural score counter.
module tb_match_ctrl;
  import pong_pkg::*;

  localparam int SD = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  match_ctrl_if bus ();

  match_ctrl #(.SERVE_DELAY(SD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Score counter: score_clear is its reset, playing lags the scores by one edge.
  logic [3:0] score1     = 4'd0;
  logic [3:0] score2     = 4'd0;
  logic       sc_playing = 1'b1;
  logic       sc_winner  = 1'b0;

  always @(posedge clk) begin
    if (bus.score_clear) begin
      score1 <= 4'd0;
      score2 <= 4'd0;
    end else begin
      if (bus.point1) score1 <= score1 + 4'd1;
      if (bus.point2) score2 <= score2 + 4'd1;
    end
    sc_playing <= (score1 < WIN_SCORE) && (score2 < WIN_SCORE);
    sc_winner  <= (score1 >= WIN_SCORE);
  end

  assign bus.playing = sc_playing;
  assign bus.winner  = sc_winner;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b1;
    repeat (3) tick;
    n_vec++; if (bus.dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    n_vec++; if (bus.ball_hold !== 1'b1) begin n_err++; $display("FAIL rst_hold: got %b want 1", bus.ball_hold); end
    n_vec++; if ({bus.point1, bus.point2, bus.score_clear, bus.serve_go} !== 4'b0000) begin n_err++; $display("FAIL rst_pulses: got %b want 0000", {bus.point1, bus.point2, bus.score_clear, bus.serve_go}); end
    n_vec++; if ({bus.serve_dir, bus.game_over, bus.winner_out} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {bus.serve_dir, bus.game_over, bus.winner_out}); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_vec++; if (bus.dbg_state !== ST_IDLE || bus.score_clear !== 1'b0 || bus.ball_hold !== 1'b1) begin
        n_err++; $display("FAIL held_start: state %0d clear %b hold %b want IDLE 0 1", bus.dbg_state, bus.score_clear, bus.ball_hold);
      end
    end
    bus.start = 1'b0;
    tick;
  endtask

  task automatic test_start;
    bus.start = 1'b1;
    tick;
    n_vec++; if (bus.score_clear !== 1'b1) begin n_err++; $display("FAIL start_clear: got %b want 1", bus.score_clear); end
    n_vec++; if (bus.dbg_state !== ST_CLEAR) begin n_err++; $display("FAIL start_state: got %0d want %0d", bus.dbg_state, ST_CLEAR); end
    bus.start = 1'b0;
    tick;
    n_vec++; if (bus.score_clear !== 1'b0) begin n_err++; $display("FAIL clear_width: got %b want 0", bus.score_clear); end
    n_vec++; if (bus.dbg_state !== ST_SERVE_WAIT) begin n_err++; $display("FAIL wait_state: got %0d want %0d", bus.dbg_state, ST_SERVE_WAIT); end
    for (int i = 0; i < SD - 1; i++) begin
      tick;
      n_vec++; if (bus.serve_go !== 1'b0 || bus.ball_hold !== 1'b1) begin n_err++; $display("FAIL early_serve: go %b hold %b want 0 1", bus.serve_go, bus.ball_hold); end
    end
    tick;
    n_vec++; if (bus.serve_go !== 1'b1) begin n_err++; $display("FAIL first_serve: got %b want 1", bus.serve_go); end
    n_vec++; if (bus.ball_hold !== 1'b0 || bus.dbg_state !== ST_RALLY) begin n_err++; $display("FAIL rally_entry: hold %b state %0d want 0 %0d", bus.ball_hold, bus.dbg_state, ST_RALLY); end
    tick;
    n_vec++; if (bus.serve_go !== 1'b0 || bus.ball_hold !== 1'b0) begin n_err++; $display("FAIL serve_width: go %b hold %b want 0 0", bus.serve_go, bus.ball_hold); end
    n_vec++; if (score1 !== 4'd0 || score2 !== 4'd0) begin n_err++; $display("FAIL start_scores: got %0d-%0d want 0-0", score1, score2); end
  endtask

  task automatic test_point_right;
    bus.out_right = 1'b1;
    tick;
    n_vec++; if ({bus.point1, bus.point2} !== 2'b10) begin n_err++; $display("FAIL pt1_pulse: got %b want 10", {bus.point1, bus.point2}); end
    n_vec++; if (bus.serve_dir !== DIR_RIGHT || bus.ball_hold !== 1'b1) begin n_err++; $display("FAIL pt1_dir_hold: dir %b hold %b want 1 1", bus.serve_dir, bus.ball_hold); end
    bus.out_right = 1'b0;
    tick;
    n_vec++; if (bus.point1 !== 1'b0 || bus.dbg_state !== ST_SETTLE) begin n_err++; $display("FAIL pt1_settle: point1 %b state %0d want 0 %0d", bus.point1, bus.dbg_state, ST_SETTLE); end
    n_vec++; if (score1 !== 4'd1) begin n_err++; $display("FAIL pt1_score: got %0d want 1", score1); end
    tick;
    n_vec++; if (bus.dbg_state !== ST_CHECK) begin n_err++; $display("FAIL pt1_check: got %0d want %0d", bus.dbg_state, ST_CHECK); end
    for (int i = 0; i < SD; i++) begin
      tick;
      n_vec++; if (bus.serve_go !== 1'b0) begin n_err++; $display("FAIL pt1_early_serve: cycle %0d got 1 want 0", i); end
    end
    tick;
    n_vec++; if (bus.serve_go !== 1'b1) begin n_err++; $display("FAIL pt1_reserve: got %b want 1", bus.serve_go); end
    tick;
  endtask

  task automatic test_let;
    bus.out_left  = 1'b1;
    bus.out_right = 1'b1;
    tick;
    n_vec++; if ({bus.point1, bus.point2} !== 2'b00) begin n_err++; $display("FAIL let_pulse: got %b want 00", {bus.point1, bus.point2}); end
    n_vec++; if (bus.dbg_state !== ST_SERVE_WAIT || bus.serve_dir !== DIR_RIGHT) begin n_err++; $display("FAIL let_state: state %0d dir %b want %0d 1", bus.dbg_state, bus.serve_dir, ST_SERVE_WAIT); end
    bus.out_left  = 1'b0;
    bus.out_right = 1'b0;
    for (int i = 0; i < SD - 1; i++) begin
      tick;
      n_vec++; if (bus.serve_go !== 1'b0) begin n_err++; $display("FAIL let_early_serve: cycle %0d got 1 want 0", i); end
    end
    tick;
    n_vec++; if (bus.serve_go !== 1'b1) begin n_err++; $display("FAIL let_reserve: got %b want 1", bus.serve_go); end
    n_vec++; if (score1 !== 4'd1 || score2 !== 4'd0) begin n_err++; $display("FAIL let_scores: got %0d-%0d want 1-0", score1, score2); end
    tick;
  endtask

  task automatic test_game_over;
    for (int ev = 1; ev <= WIN_SCORE; ev++) begin
      bus.out_left = 1'b1;
      tick;
      n_vec++; if ({bus.point1, bus.point2} !== 2'b01 || bus.serve_dir !== DIR_LEFT) begin
        n_err++; $display("FAIL pt2_pulse_%0d: pulses %b dir %b want 01 0", ev, {bus.point1, bus.point2}, bus.serve_dir);
      end
      bus.out_left = 1'b0;
      tick;
      n_vec++; if (score2 !== 4'(ev)) begin n_err++; $display("FAIL pt2_score_%0d: got %0d want %0d", ev, score2, ev); end
      tick;
      n_vec++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL early_over_%0d: got 1 want 0", ev); end
      if (ev < WIN_SCORE) begin
        repeat (SD) tick;
        tick;
        n_vec++; if (bus.serve_go !== 1'b1) begin n_err++; $display("FAIL pt2_reserve_%0d: got %b want 1", ev, bus.serve_go); end
      end
    end
    tick;
    n_vec++; if (bus.game_over !== 1'b1 || bus.dbg_state !== ST_OVER) begin n_err++; $display("FAIL over: game_over %b state %0d want 1 %0d", bus.game_over, bus.dbg_state, ST_OVER); end
    n_vec++; if (bus.winner_out !== 1'b0 || bus.ball_hold !== 1'b1) begin n_err++; $display("FAIL over_winner: winner %b hold %b want 0 1", bus.winner_out, bus.ball_hold); end
    bus.out_right = 1'b1;
    tick;
    n_vec++; if ({bus.point1, bus.point2} !== 2'b00) begin n_err++; $display("FAIL over_ignore_r: got %b want 00", {bus.point1, bus.point2}); end
    bus.out_right = 1'b0;
    bus.out_left  = 1'b1;
    tick;
    bus.out_left = 1'b0;
    tick;
    n_vec++; if (score1 !== 4'd1 || score2 !== 4'd7 || bus.game_over !== 1'b1) begin
      n_err++; $display("FAIL over_ignore: scores %0d-%0d game_over %b want 1-7 1", score1, score2, bus.game_over);
    end
    bus.start = 1'b1;
    tick;
    n_vec++; if (bus.score_clear !== 1'b1 || bus.game_over !== 1'b0) begin n_err++; $display("FAIL rematch: clear %b game_over %b want 1 0", bus.score_clear, bus.game_over); end
    bus.start = 1'b0;
    tick;
    n_vec++; if (score1 !== 4'd0 || score2 !== 4'd0 || bus.serve_dir !== DIR_LEFT) begin
      n_err++; $display("FAIL rematch_clear: scores %0d-%0d dir %b want 0-0 0", score1, score2, bus.serve_dir);
    end
    repeat (SD - 1) tick;
    n_vec++; if (bus.serve_go !== 1'b0) begin n_err++; $display("FAIL rematch_early: got 1 want 0"); end
    tick;
    n_vec++; if (bus.serve_go !== 1'b1) begin n_err++; $display("FAIL rematch_serve: got %b want 1", bus.serve_go); end
  endtask

  task automatic test_reset_mid;
    reset = 1'b0;
    tick;
    n_vec++; if (bus.dbg_state !== ST_IDLE || bus.ball_hold !== 1'b1) begin n_err++; $display("FAIL rally_rst: state %0d hold %b want IDLE 1", bus.dbg_state, bus.ball_hold); end
    reset = 1'b1;
    for (int i = 0; i < 2 * SD; i++) begin
      tick;
      n_vec++; if (bus.serve_go !== 1'b0 || bus.dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rally_rst_idle: go %b state %0d want 0 IDLE", bus.serve_go, bus.dbg_state); end
    end
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    n_vec++; if (bus.dbg_state !== ST_SERVE_WAIT) begin n_err++; $display("FAIL mid_wait: got %0d want %0d", bus.dbg_state, ST_SERVE_WAIT); end
    reset = 1'b0;
    tick;
    n_vec++; if (bus.dbg_state !== ST_IDLE) begin n_err++; $display("FAIL wait_rst: got %0d want IDLE", bus.dbg_state); end
    reset = 1'b1;
    for (int i = 0; i < 2 * SD; i++) begin
      tick;
      n_vec++; if (bus.serve_go !== 1'b0 || bus.dbg_state !== ST_IDLE) begin n_err++; $display("FAIL wait_rst_idle: go %b state %0d want 0 IDLE", bus.serve_go, bus.dbg_state); end
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.start     = 1'b1;
    bus.out_left  = 1'b0;
    bus.out_right = 1'b0;
    test_reset;
    test_start;
    test_point_right;
    test_let;
    test_game_over;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
